execute_pipe: RTL and testbench

Parametrised, pipelined successor to the sequential Y86 execute stage.
- Computes valE and the branch/cmov condition from a registered condition-code register (ZF/SF/OF), and updates CC only for OPq.
- Owns the E→M pipeline register, with stall/bubble control and exception-gated CC writes.
- Sits between decode (E-register inputs) and memory; also drives combinational forwarding outputs back to decode.

---
 rtl/y86_pkg.sv | 62 ++++++
 rtl/cond_eval.sv | 30 +++
 rtl/execute_pipe.sv | 145 ++++++++++++++
 tb/tb_execute_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU and condition function codes,
// status codes, the "no register" id and the control half of the M register.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_fn_e;

    typedef enum logic [3:0] {
        C_ALL = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_fn_e;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0] stat;
        logic [3:0] icode;
        logic       cnd;
        logic [3:0] dste;
        logic [3:0] dstm;
    } m_ctrl_t;

    localparam m_ctrl_t M_CTRL_NOP = '{
        stat:  S_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        dste:  RNONE,
        dstm:  RNONE
    };

    function automatic logic alu_fn_ok(input logic [3:0] ifun);
        return ifun <= 4'd3;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch / conditional-move condition from a set of condition codes.
// Ports: ifun (condition fn), zf/sf/of (flags) -> cnd (condition holds).
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        unique case (1'b1)
            (ifun == C_ALL): cnd = 1'b1;
            (ifun == C_LE):  cnd = lt | zf;
            (ifun == C_L):   cnd = lt;
            (ifun == C_E):   cnd = zf;
            (ifun == C_NE):  cnd = ~zf;
            (ifun == C_GE):  cnd = ~lt;
            (ifun == C_G):   cnd = ~(lt | zf);
            default:         cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_pipe.sv
// Pipelined Y86 execute stage: ALU, condition codes, E->M register.
// Ports: clk/rst, E_* decode-side inputs, M_stall/M_bubble/m_exc/W_exc
// control, M_* registered outputs, cc_* flags, e_valE/e_dstE forwarding.
module execute_pipe
    import y86_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int WORD_BYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic             M_stall,
    input  logic             M_bubble,
    input  logic             m_exc,
    input  logic             W_exc,
    output logic [2:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);

    logic [WIDTH-1:0] alu_r;
    logic             alu_of;
    logic             is_op;
    logic             op_ok;
    logic             cc_we;
    logic             cnd_raw;
    logic             e_cnd;
    logic [2:0]       e_stat;
    m_ctrl_t          m_ctrl;

    assign is_op = (E_icode == I_OPQ);
    assign op_ok = is_op & alu_fn_ok(E_ifun);

    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (E_ifun)
            ALU_ADD: begin
                alu_r  = E_valB + E_valA;
                alu_of = (E_valA[MSB] == E_valB[MSB])
                       & (alu_r[MSB] != E_valB[MSB]);
            end
            ALU_SUB: begin
                alu_r  = E_valB - E_valA;
                alu_of = (E_valA[MSB] != E_valB[MSB])
                       & (alu_r[MSB] != E_valB[MSB]);
            end
            ALU_AND: alu_r = E_valB & E_valA;
            ALU_XOR: alu_r = E_valB ^ E_valA;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        e_valE = '0;
        case (E_icode)
            I_RRMOVQ:         e_valE = E_valA;
            I_IRMOVQ:         e_valE = E_valC;
            I_RMMOVQ,
            I_MRMOVQ:         e_valE = E_valB + E_valC;
            I_OPQ:            e_valE = alu_r;
            I_CALL, I_PUSHQ:  e_valE = E_valB - STEP;
            I_RET, I_POPQ:    e_valE = E_valB + STEP;
            default:          e_valE = '0;
        endcase
    end

    // Condition is taken from the registered CC, never this cycle's ALU.
    cond_eval u_cond (
        .ifun (E_ifun),
        .zf   (cc_zf),
        .sf   (cc_sf),
        .of   (cc_of),
        .cnd  (cnd_raw)
    );

    assign e_cnd = cnd_raw
                 & ((E_icode == I_RRMOVQ) | (E_icode == I_JXX));

    // A failed cmov must not write its destination.
    assign e_dstE = ((E_icode == I_RRMOVQ) & ~e_cnd) ? RNONE : E_dstE;

    assign e_stat = (is_op & ~op_ok & (E_stat == S_AOK))
                  ? S_INS : E_stat;

    assign cc_we = op_ok & (E_stat == S_AOK)
                 & ~m_exc & ~W_exc & ~M_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (cc_we) begin
            cc_zf <= (alu_r == '0);
            cc_sf <= alu_r[MSB];
            cc_of <= alu_of;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            m_ctrl <= M_CTRL_NOP;
            M_valE <= '0;
            M_valA <= '0;
        end else if (!M_stall) begin
            m_ctrl <= '{
                stat:  e_stat,
                icode: E_icode,
                cnd:   e_cnd,
                dste:  e_dstE,
                dstm:  E_dstM
            };
            M_valE <= e_valE;
            M_valA <= E_valA;
        end
    end

    assign M_stat  = m_ctrl.stat;
    assign M_icode = m_ctrl.icode;
    assign M_cnd   = m_ctrl.cnd;
    assign M_dstE  = m_ctrl.dste;
    assign M_dstM  = m_ctrl.dstm;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed steps then random traffic against a
// behavioural model; a 32-bit instance covers the narrow stack step.
module tb_execute_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, M_stall, M_bubble, m_exc, W_exc;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;

    logic [2:0]  M_stat;
    logic [3:0]  M_icode, M_dstE, M_dstM, e_dstE;
    logic        M_cnd, cc_zf, cc_sf, cc_of;
    logic [63:0] M_valE, M_valA, e_valE;

    logic [2:0]  n_stat;
    logic [3:0]  n_icode, n_dstE, n_dstM, n_edstE;
    logic        n_cnd, n_zf, n_sf, n_of;
    logic [31:0] n_valE, n_valA, n_evalE;

    int checks = 0;
    int errors = 0;

    // model state
    logic        mz = 1'b1, ms = 1'b0, mo = 1'b0;
    logic [2:0]  xs;
    logic [3:0]  xi, xde, xdm;
    logic        xc;
    logic [63:0] xve, xva;

    execute_pipe #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .m_exc(m_exc), .W_exc(W_exc),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .e_valE(e_valE), .e_dstE(e_dstE)
    );

    execute_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC[31:0]), .E_valA(E_valA[31:0]),
        .E_valB(E_valB[31:0]),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .m_exc(m_exc), .W_exc(W_exc),
        .M_stat(n_stat), .M_icode(n_icode), .M_cnd(n_cnd),
        .M_valE(n_valE), .M_valA(n_valA),
        .M_dstE(n_dstE), .M_dstM(n_dstM),
        .cc_zf(n_zf), .cc_sf(n_sf), .cc_of(n_of),
        .e_valE(n_evalE), .e_dstE(n_edstE)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_vale(
        input logic [3:0] ic, input logic [3:0] fn,
        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: case (fn)
                4'h0: return b + a;
                4'h1: return b - a;
                4'h2: return b & a;
                4'h3: return b ^ a;
                default: return 64'd0;
            endcase
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] fn,
        input logic z, input logic s, input logic o);
        bit less;
        less = (s != o);
        case (fn)
            4'h0: return 1'b1;
            4'h1: return less || z;
            4'h2: return less;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return !less;
            4'h6: return !(less || z);
            default: return 1'b0;
        endcase
    endfunction

    task automatic ctl(input logic r, input logic st, input logic bb,
                       input logic me, input logic we);
        rst = r; M_stall = st; M_bubble = bb; m_exc = me; W_exc = we;
    endtask

    task automatic set_in(input logic [2:0] s, input logic [3:0] ic,
        input logic [3:0] fn, input logic [63:0] c, input logic [63:0] a,
        input logic [63:0] b, input logic [3:0] de, input logic [3:0] dm);
        E_stat = s; E_icode = ic; E_ifun = fn;
        E_valC = c; E_valA = a; E_valB = b;
        E_dstE = de; E_dstM = dm;
    endtask

    task automatic model_nop();
        xs = 3'd1; xi = 4'h1; xc = 1'b0;
        xve = 64'd0; xva = 64'd0; xde = 4'hF; xdm = 4'hF;
    endtask

    // One clock: check forwarding, predict the edge, check registers.
    task automatic step(input string tag);
        logic [63:0] v;
        logic        c, we, fz, fs, fo;
        logic [3:0]  fd;
        logic signed [64:0] wide;
        v  = ref_vale(E_icode, E_ifun, E_valA, E_valB, E_valC);
        c  = (E_icode == 4'h2 || E_icode == 4'h7)
             ? ref_cond(E_ifun, mz, ms, mo) : 1'b0;
        fd = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
        #2;
        chk({tag, ".e_valE"}, e_valE, v);
        chk({tag, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, fd});
        fz = (v == 64'd0);
        fs = v[63];
        fo = 1'b0;
        if (E_ifun == 4'h0) begin
            wide = $signed({E_valB[63], E_valB})
                 + $signed({E_valA[63], E_valA});
            fo = (wide[64] != wide[63]);
        end else if (E_ifun == 4'h1) begin
            wide = $signed({E_valB[63], E_valB})
                 - $signed({E_valA[63], E_valA});
            fo = (wide[64] != wide[63]);
        end
        we = (E_icode == 4'h6) && (E_ifun <= 4'd3) && (E_stat == 3'd1)
             && !m_exc && !W_exc && !M_stall;
        @(posedge clk);
        if (rst) begin
            model_nop();
            mz = 1'b1; ms = 1'b0; mo = 1'b0;
        end else begin
            if (M_bubble) model_nop();
            else if (!M_stall) begin
                xs = (E_icode == 4'h6 && E_ifun > 4'd3 && E_stat == 3'd1)
                     ? 3'd4 : E_stat;
                xi = E_icode; xc = c; xve = v; xva = E_valA;
                xde = fd; xdm = E_dstM;
            end
            if (we) begin
                mz = fz; ms = fs; mo = fo;
            end
        end
        #1;
        chk({tag, ".M_stat"}, {61'd0, M_stat}, {61'd0, xs});
        chk({tag, ".M_icode"}, {60'd0, M_icode}, {60'd0, xi});
        chk({tag, ".M_cnd"}, {63'd0, M_cnd}, {63'd0, xc});
        chk({tag, ".M_valE"}, M_valE, xve);
        chk({tag, ".M_valA"}, M_valA, xva);
        chk({tag, ".M_dstE"}, {60'd0, M_dstE}, {60'd0, xde});
        chk({tag, ".M_dstM"}, {60'd0, M_dstM}, {60'd0, xdm});
        chk({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of},
            {61'd0, mz, ms, mo});
    endtask

    initial begin
        model_nop();
        ctl(1, 0, 0, 0, 0);
        set_in(1, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
        step("reset0");
        step("reset1");
        chk("reset32.icode", {60'd0, n_icode}, 64'h1);
        ctl(0, 0, 0, 0, 0);
        step("idle");

        set_in(1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h4, 4'hF);
        step("sub_eq");
        set_in(1, 4'h7, 4'h2, 64'h40, 0, 0, 4'hF, 4'hF);
        step("jl");
        set_in(1, 4'h6, 4'h0, 0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF);
        step("add_ovf");
        set_in(1, 4'h2, 4'h2, 0, 64'h1234, 0, 4'h3, 4'hF);
        step("cmovl");
        set_in(1, 4'h2, 4'h0, 0, 64'h55, 0, 4'h6, 4'hF);
        step("rrmovq");

        ctl(0, 0, 0, 1, 0);
        set_in(1, 4'h6, 4'h3, 0, 64'h0FF0, 64'hF0F0, 4'h5, 4'hF);
        step("xor_mexc");
        ctl(0, 1, 0, 0, 0);
        step("stall0");
        step("stall1");

        ctl(0, 0, 0, 0, 0);
        set_in(1, 4'hA, 4'h0, 0, 64'h77, 64'h100, 4'h4, 4'hF);
        step("push");
        chk("push32.M_valE", {32'd0, n_valE}, 64'hFC);
        set_in(1, 4'hB, 4'h0, 0, 64'h77, 64'h100, 4'h4, 4'h7);
        step("pop");
        set_in(1, 4'h5, 4'h0, 64'h10, 64'h9, 64'h20, 4'hF, 4'h3);
        step("mrmovq");
        set_in(1, 4'h6, 4'h7, 0, 64'h3, 64'h4, 4'h1, 4'hF);
        step("op_bad");
        set_in(3'd2, 4'h6, 4'h9, 0, 64'h3, 64'h4, 4'h1, 4'hF);
        step("op_bad_hlt");

        ctl(0, 1, 1, 0, 0);
        set_in(1, 4'h6, 4'h0, 0, 64'h1, 64'h2, 4'h1, 4'hF);
        step("bub_stall");
        ctl(0, 0, 0, 0, 0);
        set_in(1, 4'h3, 4'h0, 64'hABCD, 0, 0, 4'h8, 4'hF);
        step("irmovq");
        ctl(1, 0, 0, 0, 0);
        step("midreset");
        ctl(0, 0, 0, 0, 0);
        set_in(1, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF);
        step("post_reset");

        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic;
            logic [63:0] a, b;
            case ($urandom_range(0, 3))
                0: ic = 4'h6;
                1: ic = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h7;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = b;
            if ($urandom_range(0, 3) == 0) a[63] = ~a[63];
            set_in(($urandom_range(0, 7) == 0)
                   ? 3'($urandom_range(0, 7)) : 3'd1,
                   ic, 4'($urandom_range(0, 8)),
                   {$urandom, $urandom}, a, b,
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            ctl($urandom_range(0, 49) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
